// File: rtl/vga_anim_sequencer.sv
`timescale 1ns/1ps
// Display-mode sequencer that chooses the pattern mode, advances the animation phase on each frame,
// and blanks the output for a fixed number of frames whenever the mode changes.
module vga_anim_sequencer #(
  parameter int DWELL_FRAMES = 256,
  parameter int TRANS_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto_en,
  input  logic [2:0] speed,
  output logic [1:0] mode,
  output logic [9:0] anim_count,
  output logic [9:0] frame_count,
  output logic       blank,
  output logic       running,
  output logic       frame_tick
);

  localparam logic [8:0] DWELL_LAST = 9'(DWELL_FRAMES - 1);
  localparam logic [3:0] TRANS_LAST = 4'(TRANS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, TRANS} state_t;

  state_t     state;
  logic [2:0] next_sr;   // {history, sync2, sync1}
  logic [2:0] pause_sr;
  logic       vsync_d;
  logic [8:0] dwell;
  logic [3:0] trans;
  logic       tick;
  logic       next_press;
  logic       pause_press;

  assign tick        = vsync & ~vsync_d;
  assign next_press  = next_sr[1] & ~next_sr[2];
  assign pause_press = pause_sr[1] & ~pause_sr[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_sr  <= 3'b000;
      pause_sr <= 3'b000;
      vsync_d  <= 1'b0;
    end else begin
      next_sr  <= {next_sr[1:0], btn_next};
      pause_sr <= {pause_sr[1:0], btn_pause};
      vsync_d  <= vsync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode        <= 2'd0;
      anim_count  <= 10'd0;
      frame_count <= 10'd0;
      blank       <= 1'b0;
      running     <= 1'b0;
      frame_tick  <= 1'b0;
      dwell       <= 9'd0;
      trans       <= 4'd0;
    end else begin
      frame_tick <= tick;
      if (tick)
        frame_count <= frame_count + 10'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          // A next press outranks a simultaneous pause press.
          if (next_press) begin
            state   <= TRANS;
            running <= 1'b0;
            blank   <= 1'b1;
            trans   <= 4'd0;
          end else if (pause_press) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (tick) begin
            anim_count <= anim_count + 10'(speed) + 10'd1;
            dwell      <= dwell + 9'd1;
            if (auto_en && dwell == DWELL_LAST) begin
              state   <= TRANS;
              running <= 1'b0;
              blank   <= 1'b1;
              trans   <= 4'd0;
            end
          end
        end

        PAUSED: begin
          if (next_press) begin
            state <= TRANS;
            blank <= 1'b1;
            trans <= 4'd0;
          end else if (pause_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        TRANS: begin
          // Button presses are deliberately ignored here rather than queued.
          if (tick) begin
            if (trans == TRANS_LAST) begin
              mode       <= mode + 2'd1;
              anim_count <= 10'd0;
              dwell      <= 9'd0;
              blank      <= 1'b0;
              state      <= RUN;
              running    <= 1'b1;
            end else begin
              trans <= trans + 4'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          blank   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_anim_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus updates an event-level reference model and queues the expected
// outputs per frame; a monitor compares them whenever frame_tick is presented.
module tb_vga_anim_sequencer;

  localparam int DW = 4;
  localparam int TF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_pause = 1'b0;
  logic       auto_en = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [1:0] mode;
  logic [9:0] anim_count;
  logic [9:0] frame_count;
  logic       blank;
  logic       running;
  logic       frame_tick;

  always #5 clk = ~clk;

  vga_anim_sequencer #(.DWELL_FRAMES(DW), .TRANS_FRAMES(TF)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .btn_next(btn_next), .btn_pause(btn_pause),
    .auto_en(auto_en), .speed(speed), .mode(mode), .anim_count(anim_count),
    .frame_count(frame_count), .blank(blank), .running(running), .frame_tick(frame_tick)
  );

  typedef struct {
    int mode;
    int anim;
    int frame;
    int blank;
    int running;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 run, 2 paused, 3 transition.
  int m_state, m_mode, m_anim, m_frame, m_dwell, m_trans, m_blank;

  function automatic void model_reset();
    m_state = 0; m_mode = 0; m_anim = 0; m_frame = 0;
    m_dwell = 0; m_trans = 0; m_blank = 0;
  endfunction

  function automatic void model_tick();
    exp_t e;
    int prev_dwell;
    m_frame = (m_frame + 1) % 1024;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      prev_dwell = m_dwell;
      m_anim  = (m_anim + int'(speed) + 1) % 1024;
      m_dwell = (m_dwell + 1) % 512;
      if (auto_en && prev_dwell == DW - 1) begin
        m_state = 3; m_trans = 0; m_blank = 1;
      end
    end else if (m_state == 3) begin
      m_trans = m_trans + 1;
      if (m_trans == TF) begin
        m_mode = (m_mode + 1) % 4; m_anim = 0; m_dwell = 0; m_blank = 0; m_state = 1;
      end
    end
    e.mode = m_mode; e.anim = m_anim; e.frame = m_frame;
    e.blank = m_blank; e.running = (m_state == 1) ? 1 : 0;
    q.push_back(e);
  endfunction

  function automatic void model_press(input bit n, input bit p);
    if (m_state == 1 || m_state == 2) begin
      if (n) begin
        m_state = 3; m_trans = 0; m_blank = 1;
      end else if (p) begin
        m_state = (m_state == 1) ? 2 : 1;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    vsync = 1'b1;
    model_tick();
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_press(input bit n, input bit p);
    @(negedge clk);
    btn_next  = n;
    btn_pause = p;
    model_press(n, p);
    repeat (2) @(negedge clk);
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && frame_tick) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_tick: frame_count=%0d with no expectation queued", frame_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(mode) != e.mode || int'(anim_count) != e.anim || int'(frame_count) != e.frame ||
            int'(blank) != e.blank || int'(running) != e.running) begin
          errors++;
          $display("FAIL frame_state: got mode=%0d anim=%0d frame=%0d blank=%0d run=%0d expected mode=%0d anim=%0d frame=%0d blank=%0d run=%0d",
                   mode, anim_count, frame_count, blank, running,
                   e.mode, e.anim, e.frame, e.blank, e.running);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_mode", int'(mode), 0);
    check("reset_anim", int'(anim_count), 0);
    check("reset_frame", int'(frame_count), 0);
    check("reset_blank", int'(blank), 0);
    check("reset_running", int'(running), 0);
    check("reset_frame_tick", int'(frame_tick), 0);

    // Button held across reset release: its single press lands in IDLE and must be ignored.
    btn_pause = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    btn_pause = 1'b0;
    repeat (3) @(negedge clk);
    do_press(1'b1, 1'b0);

    repeat (3) do_tick();
    check("three_ticks_anim", int'(anim_count), 2);
    check("three_ticks_frame", int'(frame_count), 3);

    speed = 3'd7;
    repeat (2) do_tick();

    do_press(1'b0, 1'b1);
    repeat (5) do_tick();
    do_press(1'b0, 1'b1);
    do_tick();

    do_press(1'b1, 1'b1);
    check("next_beats_pause_blank", int'(blank), 1);
    repeat (TF) do_tick();
    repeat (2) begin
      do_press(1'b1, 1'b0);
      repeat (TF) do_tick();
    end
    check("mode_before_wrap", int'(mode), 3);

    // Blank must rise on the third edge after the pin rises.
    @(negedge clk);
    btn_next = 1'b1;
    model_press(1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("blank_after_2_edges", int'(blank), 0);
    @(posedge clk); #1;
    check("blank_after_3_edges", int'(blank), 1);
    @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
    do_press(1'b0, 1'b1);
    repeat (TF) do_tick();

    speed = 3'd0;
    auto_en = 1'b1;
    repeat (DW + TF) do_tick();
    check("auto_advance_mode", int'(mode), 1);
    auto_en = 1'b0;

    // Asynchronous reset in the middle of a transition.
    do_press(1'b1, 1'b0);
    repeat (2) do_tick();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_blank", int'(blank), 0);
    check("async_mode", int'(mode), 0);
    check("async_running", int'(running), 0);
    check("async_frame", int'(frame_count), 0);
    check("async_anim", int'(anim_count), 0);
    model_reset();
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 160; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5) do_tick();
      else if (op == 6) do_press(1'b1, 1'b0);
      else if (op == 7) do_press(1'b0, 1'b1);
      else if (op == 8) do_press(1'b1, 1'b1);
      else begin
        @(negedge clk);
        speed   = 3'($urandom_range(0, 7));
        auto_en = 1'($urandom_range(0, 1));
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
